// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SHOW = 2'd2,
    OVER = 2'd3
  } state_t;

  // Right-shifting Galois form of x^8 + x^6 + x^5 + x^4 + 1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int CNT_W = 8;

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Galois LFSR used as the hole-selection entropy source.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= SEED;
    end else if (r_q[0]) begin
      r_q <= (r_q >> 1) ^ LFSR_TAPS;
    end else begin
      r_q <= r_q >> 1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mole_round_ctrl.sv
// Round sequencer: picks a hole, lights the mole, runs the round timer and
// scores hits versus timeouts, then pulses the sound timer on a hit.
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int         NUM_HOLES = 9,
  parameter int         ROUNDS    = 16,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 game_start,
  input  logic [NUM_HOLES-1:0] hit,
  input  logic                 timer_done,
  output logic                 timer_start,
  output logic                 sfx_start,
  output logic [NUM_HOLES-1:0] mole,
  output logic [CNT_W-1:0]     score,
  output logic [CNT_W-1:0]     misses,
  output logic [CNT_W-1:0]     round_idx,
  output logic                 busy,
  output logic                 game_over,
  output state_t               dbg_state
);

  // Timer handshake: timer_start is a level held high for the whole of SHOW;
  // timer_done is a single-cycle pulse that only counts while in SHOW. The
  // one-cycle ARM gap with timer_start low lets the timer clear between rounds.

  localparam int                 HOLE_W    = 5;
  localparam logic [HOLE_W-1:0]  NO_HOLE   = HOLE_W'(NUM_HOLES);
  localparam logic [HOLE_W-1:0]  LAST_HOLE = HOLE_W'(NUM_HOLES - 1);
  localparam logic [7:0]         NH8       = 8'(NUM_HOLES);
  localparam logic [CNT_W-1:0]   ROUNDS_C  = CNT_W'(ROUNDS);

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           w_lfsr;
  logic [HOLE_W-1:0]    r_prev_hole;
  logic [HOLE_W-1:0]    w_h_raw;
  logic [HOLE_W-1:0]    w_h_inc;
  logic [HOLE_W-1:0]    w_hole;
  logic [NUM_HOLES-1:0] r_mole;
  logic [NUM_HOLES-1:0] w_onehot;
  logic [CNT_W-1:0]     r_score;
  logic [CNT_W-1:0]     r_misses;
  logic [CNT_W-1:0]     r_round;
  logic                 r_sfx;
  logic                 w_hit_ok;
  logic                 w_round_end;
  logic                 w_last;

  mole_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .q  (w_lfsr)
  );

  // Never light the same hole twice in a row; bump to the next hole instead.
  assign w_h_raw  = HOLE_W'(w_lfsr % NH8);
  assign w_h_inc  = (w_h_raw == LAST_HOLE) ? '0 : w_h_raw + HOLE_W'(1);
  assign w_hole   = (w_h_raw == r_prev_hole) ? w_h_inc : w_h_raw;
  assign w_onehot = {{(NUM_HOLES-1){1'b0}}, 1'b1} << w_hole;

  // A correct hit takes priority over a simultaneous timeout.
  assign w_hit_ok    = |(hit & r_mole);
  assign w_round_end = w_hit_ok | timer_done;
  assign w_last      = (r_round + CNT_W'(1)) == ROUNDS_C;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (game_start) w_next = ARM;
      ARM:     w_next = SHOW;
      SHOW:    if (w_round_end) w_next = w_last ? OVER : ARM;
      OVER:    if (game_start) w_next = ARM;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mole      <= '0;
      r_prev_hole <= NO_HOLE;
      r_score     <= '0;
      r_misses    <= '0;
      r_round     <= '0;
      r_sfx       <= 1'b0;
    end else begin
      r_sfx <= 1'b0;
      case (r_state)
        IDLE, OVER: begin
          if (game_start) begin
            r_score  <= '0;
            r_misses <= '0;
            r_round  <= '0;
          end
        end
        ARM: begin
          r_mole      <= w_onehot;
          r_prev_hole <= w_hole;
        end
        SHOW: begin
          if (w_hit_ok) begin
            r_score <= r_score + CNT_W'(1);
            r_round <= r_round + CNT_W'(1);
            r_sfx   <= 1'b1;
            r_mole  <= '0;
          end else if (timer_done) begin
            r_misses <= r_misses + CNT_W'(1);
            r_round  <= r_round + CNT_W'(1);
            r_mole   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign timer_start = (r_state == SHOW);
  assign busy        = (r_state == ARM) || (r_state == SHOW);
  assign game_over   = (r_state == OVER);
  assign sfx_start   = r_sfx;
  assign mole        = r_mole;
  assign score       = r_score;
  assign misses      = r_misses;
  assign round_idx   = r_round;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl: driver pushes expected round outcomes,
// a negedge monitor pops and compares whenever a round ends.
module tb_mole_round_ctrl;
  import mole_pkg::*;

  localparam int         NH   = 9;
  localparam int         NR   = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic          game_start;
  logic [NH-1:0] hit;
  logic          timer_done;
  logic          timer_start;
  logic          sfx_start;
  logic [NH-1:0] mole;
  logic [7:0]    score;
  logic [7:0]    misses;
  logic [7:0]    round_idx;
  logic          busy;
  logic          game_over;
  state_t        dbg_state;

  always #5 clk = ~clk;

  mole_round_ctrl #(
    .NUM_HOLES(NH),
    .ROUNDS   (NR),
    .SEED     (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .game_start (game_start),
    .hit        (hit),
    .timer_done (timer_done),
    .timer_start(timer_start),
    .sfx_start  (sfx_start),
    .mole       (mole),
    .score      (score),
    .misses     (misses),
    .round_idx  (round_idx),
    .busy       (busy),
    .game_over  (game_over),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // {score, misses, round_idx, sfx_start, game_over} seen the cycle after a round ends
  logic [25:0] exp_q[$];
  logic [25:0] mon_e;
  logic        prev_ts = 1'b0;

  int m_score;
  int m_misses;
  int m_round;
  int prev_hole;
  int cur_hole;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, right-shifting, reloaded with SEED on reset.
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= SEED;
    else      m_lfsr <= {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a falling timer_start outside reset marks the end of a round.
  always @(negedge clk) begin
    if (!rst) begin
      prev_ts = 1'b0;
    end else begin
      if (prev_ts && !timer_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL outcome: round ended with no expected entry queued");
        end else begin
          mon_e = exp_q.pop_front();
          chk("outcome", {score, misses, round_idx, sfx_start, game_over}, mon_e);
          chk("mole_drop", 32'(mole), 32'd0);
        end
      end
      prev_ts = timer_start;
    end
  end

  task automatic clear_model();
    m_score  = 0;
    m_misses = 0;
    m_round  = 0;
  endtask

  task automatic pulse_start();
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
  endtask

  // Called in the ARM cycle; leaves the bench in the first SHOW cycle.
  task automatic enter_show();
    int h;
    logic [NH-1:0] prev_vec;
    chk("arm_state", 32'(dbg_state), 32'(ARM));
    chk("arm_ts_low", 32'(timer_start), 32'd0);
    chk("arm_busy", 32'(busy), 32'd1);
    h = int'(m_lfsr) % NH;
    if (h == prev_hole) h = (h + 1) % NH;
    prev_vec = '0;
    if (prev_hole < NH) prev_vec[prev_hole] = 1'b1;
    @(negedge clk);
    cur_hole = h;
    chk("show_state", 32'(dbg_state), 32'(SHOW));
    chk("show_ts", 32'(timer_start), 32'd1);
    chk("show_mole", 32'(mole), 32'(1) << h);
    chk("no_repeat", 32'(mole & prev_vec), 32'd0);
    chk("sfx_single", 32'(sfx_start), 32'd0);
    prev_hole = h;
  endtask

  // kind: 0 hit, 1 timeout, 2 hit and timeout together.
  // extra: 0 none, 1 wrong-hole hit, 2 game_start during SHOW (uses one delay cycle).
  task automatic play(input int kind, input int delay, input int extra);
    logic [NH-1:0] vec;
    enter_show();
    for (int i = 0; i < delay; i++) begin
      if (i == 0 && extra == 1) begin
        vec = '0;
        vec[(cur_hole + 1) % NH] = 1'b1;
        hit = vec;
        @(negedge clk);
        hit = '0;
        chk("wrong_mole", 32'(mole), 32'(1) << cur_hole);
        chk("wrong_score", 32'(score), 32'(m_score));
        chk("wrong_round", 32'(round_idx), 32'(m_round));
        chk("wrong_ts", 32'(timer_start), 32'd1);
      end else if (i == 0 && extra == 2) begin
        game_start = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
        chk("gs_show_state", 32'(dbg_state), 32'(SHOW));
        chk("gs_show_round", 32'(round_idx), 32'(m_round));
      end else begin
        @(negedge clk);
      end
    end
    vec = '0;
    vec[cur_hole] = 1'b1;
    if (kind != 1) hit = vec;
    if (kind != 0) timer_done = 1'b1;
    if (kind != 1) m_score++;
    else           m_misses++;
    m_round++;
    exp_q.push_back({8'(m_score), 8'(m_misses), 8'(m_round), (kind != 1), (m_round == NR)});
    @(negedge clk);
    hit        = '0;
    timer_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    game_start = 1'b0;
    hit        = '0;
    timer_done = 1'b0;
    clear_model();
    prev_hole  = NH;
    cur_hole   = 0;

    repeat (3) @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_mole", 32'(mole), 32'd0);
    chk("rst_ts", 32'(timer_start), 32'd0);
    chk("rst_sfx", 32'(sfx_start), 32'd0);
    chk("rst_cnts", {8'h0, score, misses, round_idx}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);

    rst = 1'b1;
    @(negedge clk);
    chk("idle_hold", 32'(dbg_state), 32'(IDLE));

    // Game 1: hit, timeout, hit+timeout together, timeout.
    pulse_start();
    play(0, 3, 1);
    play(1, 2, 0);
    play(2, 0, 0);
    play(1, 1, 0);
    chk("over_state", 32'(dbg_state), 32'(OVER));
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_busy", 32'(busy), 32'd0);
    chk("over_ts", 32'(timer_start), 32'd0);
    timer_done = 1'b1;
    hit        = '1;
    @(negedge clk);
    timer_done = 1'b0;
    hit        = '0;
    @(negedge clk);
    chk("over_frozen", {8'h0, score, misses, round_idx}, {8'h0, 8'd2, 8'd2, 8'd4});
    chk("over_sfx", 32'(sfx_start), 32'd0);

    // Game 2: restart from OVER, then reset in the middle of a round.
    clear_model();
    pulse_start();
    chk("restart_cnts", {8'h0, score, misses, round_idx}, 32'd0);
    play(0, 1, 0);
    play(1, 2, 2);
    enter_show();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    chk("arst_mole", 32'(mole), 32'd0);
    chk("arst_ts", 32'(timer_start), 32'd0);
    chk("arst_cnts", {8'h0, score, misses, round_idx}, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    clear_model();
    prev_hole = NH;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Game 3: fresh start after reset, single timeout.
    pulse_start();
    play(1, 0, 0);
    @(negedge clk);
    chk("g3_sfx", 32'(sfx_start), 32'd0);
    chk("g3_state", 32'(dbg_state), 32'(SHOW));

    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
